// File: rtl/level_mask_seq_if.sv
// Handshake/bus bundle between a level_mask_seq and its driver/consumer.
// The master side drives the word and accepts masks; the slave side is the sequencer.
interface level_mask_seq_if #(
    parameter int unsigned WORD_SIZE  = 48,
    parameter int unsigned LEVEL_BITS = 4
);
    logic                            start;
    logic [LEVEL_BITS-1:0]           num_levels;
    logic [LEVEL_BITS*WORD_SIZE-1:0] data_in;
    logic                            skip_empty;
    logic                            mask_ready;
    logic                            mask_valid;
    logic [WORD_SIZE-1:0]            mask;
    logic [LEVEL_BITS-1:0]           level;
    logic                            last;
    logic                            busy;
    logic                            done;
    logic                            pattern_advance;
    logic                            range_err;

    modport master (
        output start, num_levels, data_in, skip_empty, mask_ready,
        input  mask_valid, mask, level, last, busy, done, pattern_advance, range_err
    );

    modport slave (
        input  start, num_levels, data_in, skip_empty, mask_ready,
        output mask_valid, mask, level, last, busy, done, pattern_advance, range_err
    );
endinterface

// File: rtl/level_mask_seq.sv
// Latches one bit-plane word of per-bit target levels and emits, level by level,
// the mask of bits targeting that level; pulses pattern_advance when the word is done.
module level_mask_seq #(
    parameter int unsigned WORD_SIZE  = 48,
    parameter int unsigned LEVEL_BITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    level_mask_seq_if.slave   bus
);
    localparam int unsigned DATA_W = WORD_SIZE * LEVEL_BITS;

    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    state_t                state_q, state_d;
    logic [LEVEL_BITS-1:0] level_q, level_d;
    logic [LEVEL_BITS-1:0] top_q, top_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  range_err_q, range_err_d;

    logic [WORD_SIZE-1:0]  match;
    logic [LEVEL_BITS-1:0] new_top;
    logic                  new_range_err;
    logic                  in_emit;
    logic                  empty;
    logic                  valid;

    // Gather bit i's target from the bit-planes (plane j supplies target bit j).
    function automatic logic [LEVEL_BITS-1:0] target_of(input logic [DATA_W-1:0] d,
                                                        input int unsigned i);
        logic [LEVEL_BITS-1:0] t;
        t = '0;
        for (int unsigned j = 0; j < LEVEL_BITS; j++) begin
            t[j] = d[j*WORD_SIZE + i];
        end
        return t;
    endfunction

    // Highest level index L-1 for a level-count code.
    function automatic logic [LEVEL_BITS-1:0] decode_top(input logic [LEVEL_BITS-1:0] nl);
        logic [LEVEL_BITS-1:0] top;
        case (nl)
            LEVEL_BITS'(0): top = LEVEL_BITS'(15);
            LEVEL_BITS'(8): top = LEVEL_BITS'(7);
            LEVEL_BITS'(4): top = LEVEL_BITS'(3);
            LEVEL_BITS'(2): top = LEVEL_BITS'(1);
            default:        top = LEVEL_BITS'(0);
        endcase
        return top;
    endfunction

    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < WORD_SIZE; i++) begin
            match[i] = (target_of(data_q, i) == level_q);
        end
    end

    // Out-of-range detection on the incoming word, used only when it is accepted.
    always_comb begin
        new_top       = decode_top(bus.num_levels);
        new_range_err = 1'b0;
        for (int unsigned i = 0; i < WORD_SIZE; i++) begin
            if (target_of(bus.data_in, i) > new_top) new_range_err = 1'b1;
        end
    end

    assign in_emit = (state_q == EMIT);
    assign empty   = (match == '0);
    assign valid   = in_emit && !(bus.skip_empty && empty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            level_q     <= '0;
            top_q       <= '0;
            data_q      <= '0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            top_q       <= top_d;
            data_q      <= data_d;
            range_err_q <= range_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        top_d       = top_q;
        data_d      = data_q;
        range_err_d = range_err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    data_d      = bus.data_in;
                    top_d       = new_top;
                    range_err_d = new_range_err;
                    level_d     = '0;
                    state_d     = EMIT;
                end
            end
            EMIT: begin
                // A skipped empty level advances without waiting for the consumer.
                if ((bus.skip_empty && empty) || (valid && bus.mask_ready)) begin
                    if (level_q == top_q) state_d = DONE;
                    else                  level_d = level_q + LEVEL_BITS'(1);
                end
            end
            DONE: begin
                level_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Mask and last are gated to EMIT so that everything reads zero while idle.
    assign bus.mask_valid      = valid;
    assign bus.mask            = in_emit ? match : '0;
    assign bus.level           = level_q;
    assign bus.last            = in_emit && (level_q == top_q);
    assign bus.busy            = (state_q != IDLE);
    assign bus.done            = (state_q == DONE);
    assign bus.pattern_advance = (state_q == DONE);
    assign bus.range_err       = range_err_q;
endmodule

// File: tb/tb_level_mask_seq.sv
// Directed bench for level_mask_seq: a model pushes expected beats to a queue,
// a negedge monitor pops them on each handshake and compares.
module tb_level_mask_seq;
    localparam int unsigned WS = 8;
    localparam int unsigned LB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    level_mask_seq_if #(.WORD_SIZE(WS), .LEVEL_BITS(LB)) bus ();

    level_mask_seq #(.WORD_SIZE(WS), .LEVEL_BITS(LB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [WS-1:0] mask;
        logic [LB-1:0] level;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    done_cnt = 0;
    int    done_cyc = 0;
    int    t0 = 0;
    int    done_base = 0;
    logic  exp_rerr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned nlev(input logic [LB-1:0] nl);
        case (nl)
            4'd0:    return 16;
            4'd8:    return 8;
            4'd4:    return 4;
            4'd2:    return 2;
            default: return 1;
        endcase
    endfunction

    // Targets given as nibbles (nibble i = target of bit i), converted to bit-planes.
    function automatic logic [WS*LB-1:0] planes(input logic [31:0] tn);
        logic [WS*LB-1:0] d;
        d = '0;
        for (int i = 0; i < WS; i++)
            for (int j = 0; j < LB; j++)
                d[j*WS + i] = tn[i*4 + j];
        return d;
    endfunction

    task automatic push_model(input logic [LB-1:0] nl, input logic [31:0] tn, input logic skip);
        int unsigned L;
        beat_t       b;
        logic [3:0]  t;
        L = nlev(nl);
        exp_rerr = 1'b0;
        for (int unsigned lv = 0; lv < L; lv++) begin
            b.mask = '0;
            for (int i = 0; i < WS; i++) begin
                t = tn[i*4 +: 4];
                if (32'(t) >= L) exp_rerr = 1'b1;
                b.mask[i] = (32'(t) == lv);
            end
            b.level = LB'(lv);
            b.last  = (lv == L - 1);
            if (!(skip && b.mask == '0)) exp_q.push_back(b);
        end
    endtask

    task automatic start_word(input logic [LB-1:0] nl, input logic [31:0] tn, input logic skip);
        push_model(nl, tn, skip);
        bus.start      = 1'b1;
        bus.num_levels = nl;
        bus.data_in    = planes(tn);
        bus.skip_empty = skip;
        t0             = cyc;
        done_base      = done_cnt;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic finish_word(input string tag, input int exp_idx);
        int i;
        i = 0;
        while (done_cnt == done_base && i < 200) begin
            @(posedge clk); #1;
            i++;
        end
        chk({tag, "_done_seen"},  64'(done_cnt - done_base), 64'd1);
        chk({tag, "_done_cycle"}, 64'(done_cyc - t0), 64'(exp_idx));
        chk({tag, "_idle"},       64'(bus.busy), 64'd0);
        chk({tag, "_drained"},    64'(exp_q.size()), 64'd0);
        chk({tag, "_range_err"},  64'(bus.range_err), 64'(exp_rerr));
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 64'({bus.mask_valid, bus.mask, bus.level, bus.last, bus.busy,
                      bus.done, bus.pattern_advance, bus.range_err}), 64'd0);
    endtask

    // Scoreboard side: every valid cycle is checked against the queue head,
    // so a stalled mask must stay identical until it is accepted.
    always @(negedge clk) begin
        if (!rst) begin
            chk("pa_eq_done", 64'(bus.pattern_advance), 64'(bus.done));
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.mask_valid) begin
                chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    chk("beat_mask",  64'(bus.mask),  64'(exp_q[0].mask));
                    chk("beat_level", 64'(bus.level), 64'(exp_q[0].level));
                    chk("beat_last",  64'(bus.last),  64'(exp_q[0].last));
                    if (bus.mask_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        bus.start      = 1'b0;
        bus.num_levels = '0;
        bus.data_in    = '0;
        bus.skip_empty = 1'b0;
        bus.mask_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk_all_zero("reset_outputs");
        rst = 1'b0;
        @(posedge clk); #1;

        // L=4, target(i)=i%4, always ready: 0x11,0x22,0x44,0x88 then done at 5
        start_word(4'd4, 32'h3210_3210, 1'b0);
        finish_word("l4_ready", 5);

        // Same word, consumer stalls 3 cycles on level 1
        start_word(4'd4, 32'h3210_3210, 1'b0);
        @(posedge clk); #1;
        bus.mask_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        bus.mask_ready = 1'b1;
        finish_word("l4_stall", 8);

        // L=16, all targets 5, with and without skipping empty levels
        start_word(4'd0, 32'h5555_5555, 1'b1);
        finish_word("l16_skip", 17);
        start_word(4'd0, 32'h5555_5555, 1'b0);
        finish_word("l16_noskip", 17);

        // L=8 with sparse targets and skipping: timing is independent of skips
        start_word(4'd8, 32'h7070_0707, 1'b1);
        finish_word("l8_skip", 9);

        // L=2 with out-of-range targets on bits 2 and 5
        start_word(4'd2, 32'h1021_0310, 1'b0);
        finish_word("l2_range", 3);

        // Unlisted code decodes to L=1
        start_word(4'd7, 32'h0000_0000, 1'b0);
        finish_word("l1_code7", 2);

        // start held through DONE is accepted only in the following IDLE cycle
        push_model(4'd7, 32'h0000_0000, 1'b0);
        push_model(4'd7, 32'h0000_0000, 1'b0);
        bus.start      = 1'b1;
        bus.num_levels = 4'd7;
        bus.data_in    = planes(32'h0000_0000);
        bus.skip_empty = 1'b0;
        t0             = cyc;
        done_base      = done_cnt;
        @(posedge clk); #1;
        chk("hold_emit_busy", 64'(bus.busy), 64'd1);
        @(posedge clk); #1;
        chk("hold_done", 64'(bus.done), 64'd1);
        @(posedge clk); #1;
        chk("hold_idle_busy", 64'(bus.busy), 64'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("hold_second_emit", 64'(bus.busy), 64'd1);
        chk("hold_second_level", 64'(bus.level), 64'd0);
        @(posedge clk); #1;
        chk("hold_second_done", 64'(bus.done), 64'd1);
        @(posedge clk); #1;
        chk("hold_done_count", 64'(done_cnt - done_base), 64'd2);
        chk("hold_idle_end", 64'(bus.busy), 64'd0);
        chk("hold_drained", 64'(exp_q.size()), 64'd0);

        // Reset mid-word at level 2 of 4
        start_word(4'd4, 32'h3210_3210, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_pre_level", 64'(bus.level), 64'd2);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid_outputs");
        exp_q.delete();
        done_base = done_cnt;
        @(posedge clk); #1;
        chk_all_zero("rst_held_outputs");
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_no_done", 64'(done_cnt - done_base), 64'd0);
        chk_all_zero("rst_after_outputs");

        // Sequencer is usable again after reset
        start_word(4'd4, 32'h3210_3210, 1'b0);
        finish_word("post_rst", 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
